// File: rtl/lut_v_bank.sv
// Runtime-loadable V lookup table for the AV1 range stage: a valid/ready load port fills
// the table once after reset, then NUM_CH independent read channels return registered results.
module lut_v_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int READ_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [DATA_WIDTH-1:0]        load_data,
    output logic                         load_ready,
    output logic                         load_done,
    output logic                         table_ready,
    input  logic [NUM_CH-1:0]            rd_valid,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_CH-1:0]            rd_data_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_LOADING = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  last_beat;
    logic                  rd_err_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_en     = 1'b0;
        wr_addr   = ptr_q[ADDR_WIDTH-1:0];
        last_beat = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (load_start) begin
                    state_d = ST_LOADING;
                    ptr_d   = '0;
                end
            end
            ST_LOADING: begin
                if (load_start) begin
                    // A beat arriving with a restart lands at address 0.
                    wr_addr = '0;
                    wr_en   = load_valid;
                    ptr_d   = load_valid ? (ADDR_WIDTH + 1)'(1) : '0;
                end else if (load_valid) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        last_beat = 1'b1;
                        state_d   = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (load_start) begin
                    state_d = ST_LOADING;
                    ptr_d   = '0;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (reset) begin
            wr_en     = 1'b0;
            last_beat = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            ptr_q    <= '0;
            rd_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if ((|rd_valid) && (state_q != ST_READY)) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    // NOTE: the table RAM is deliberately not reset; contents are only trusted after a full load.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= load_data;
        end
    end

    assign load_ready  = (state_q == ST_LOADING);
    assign load_done   = last_beat;
    assign table_ready = (state_q == ST_READY);
    assign rd_err      = rd_err_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [ADDR_WIDTH-1:0] addr;
        logic                  accept;
        logic                  v1_q;
        logic [DATA_WIDTH-1:0] d1_q;

        assign addr   = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign accept = rd_valid[k] && (state_q == ST_READY);

        // Data only moves on a valid result so the output holds between reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                v1_q <= 1'b0;
                d1_q <= '0;
            end else begin
                v1_q <= accept;
                if (accept) begin
                    d1_q <= mem[addr];
                end
            end
        end

        if (READ_LAT == 2) begin : g_lat2
            logic                  v2_q;
            logic [DATA_WIDTH-1:0] d2_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        d2_q <= d1_q;
                    end
                end
            end

            assign rd_data_valid[k]                    = v2_q;
            assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = d2_q;
        end else begin : g_lat1
            assign rd_data_valid[k]                    = v1_q;
            assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = d1_q;
        end
    end

endmodule

// File: tb/tb_lut_v_bank.sv
// Drives a READ_LAT=1 and a READ_LAT=2 instance with identical stimulus and checks both
// against a cycle-indexed table model: a read accepted in cycle t shows up at t+READ_LAT.
module tb_lut_v_bank;

    localparam int DW     = 16;
    localparam int AW     = 8;
    localparam int NCH    = 2;
    localparam int DEPTH  = 256;
    localparam int MAXCYC = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, load_start, load_valid;
    logic [DW-1:0]      load_data;
    logic [NCH-1:0]     rd_valid;
    logic [NCH*AW-1:0]  rd_addr;

    logic               l1_load_ready, l1_load_done, l1_table_ready, l1_rd_err;
    logic [NCH-1:0]     l1_rd_data_valid;
    logic [NCH*DW-1:0]  l1_rd_data;
    logic               l2_load_ready, l2_load_done, l2_table_ready, l2_rd_err;
    logic [NCH-1:0]     l2_rd_data_valid;
    logic [NCH*DW-1:0]  l2_rd_data;

    lut_v_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(l1_load_ready), .load_done(l1_load_done),
        .table_ready(l1_table_ready), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_data_valid(l1_rd_data_valid), .rd_data(l1_rd_data), .rd_err(l1_rd_err)
    );

    lut_v_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .READ_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(l2_load_ready), .load_done(l2_load_done),
        .table_ready(l2_table_ready), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_data_valid(l2_rd_data_valid), .rd_data(l2_rd_data), .rd_err(l2_rd_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: table contents, load progress, and per-cycle accepted reads.
    typedef enum int {M_EMPTY, M_LOADING, M_READY} mstate_t;
    mstate_t       m_state;
    int            m_ptr;
    bit            m_err;
    logic [DW-1:0] m_mem [DEPTH];
    bit            hist_v [MAXCYC][NCH];
    logic [DW-1:0] hist_d [MAXCYC][NCH];
    logic [DW-1:0] hold   [2][NCH];
    int            cyc;
    int            done_seen;
    int            ready_cycles;

    task automatic model_reset();
        m_state = M_EMPTY;
        m_ptr   = 0;
        m_err   = 1'b0;
        for (int l = 0; l < 2; l++)
            for (int k = 0; k < NCH; k++)
                hold[l][k] = '0;
    endtask

    task automatic idle_inputs();
        reset      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        rd_valid   = '0;
        rd_addr    = '0;
    endtask

    // One clock: inputs are already driven; checks mid-cycle, then #1 after the edge.
    task automatic step();
        bit exp_lr, exp_ld, exp_tr, err_set;
        logic [AW-1:0] a;
        if (cyc >= MAXCYC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXCYC);
            $fatal(1, "cycle budget exhausted");
        end
        #3;
        exp_lr = (m_state == M_LOADING);
        exp_ld = !reset && exp_lr && load_valid && !load_start && (m_ptr == DEPTH - 1);
        exp_tr = (m_state == M_READY);
        check("lat1_load_ready",  l1_load_ready,  exp_lr);
        check("lat2_load_ready",  l2_load_ready,  exp_lr);
        check("lat1_load_done",   l1_load_done,   exp_ld);
        check("lat2_load_done",   l2_load_done,   exp_ld);
        check("lat1_table_ready", l1_table_ready, exp_tr);
        check("lat2_table_ready", l2_table_ready, exp_tr);
        if (l1_load_done === 1'b1) done_seen++;
        if (l1_load_ready === 1'b1) ready_cycles++;

        for (int k = 0; k < NCH; k++) begin
            a = rd_addr[k*AW +: AW];
            hist_v[cyc][k] = !reset && rd_valid[k] && (m_state == M_READY);
            hist_d[cyc][k] = m_mem[a];
        end
        err_set = (|rd_valid) && (m_state != M_READY);

        @(posedge clk);
        if (reset) begin
            model_reset();
            for (int k = 0; k < NCH; k++) begin
                hist_v[cyc][k] = 1'b0;
                if (cyc > 0) hist_v[cyc-1][k] = 1'b0;
            end
        end else begin
            if (err_set) m_err = 1'b1;
            case (m_state)
                M_EMPTY: if (load_start) begin m_state = M_LOADING; m_ptr = 0; end
                M_LOADING: begin
                    if (load_start) begin
                        if (load_valid) begin m_mem[0] = load_data; m_ptr = 1; end
                        else m_ptr = 0;
                    end else if (load_valid) begin
                        m_mem[m_ptr] = load_data;
                        if (m_ptr == DEPTH - 1) m_state = M_READY;
                        m_ptr++;
                    end
                end
                default: if (load_start) begin m_state = M_LOADING; m_ptr = 0; end
            endcase
        end

        #1;
        for (int l = 1; l <= 2; l++) begin
            for (int k = 0; k < NCH; k++) begin
                int r;
                bit ev;
                logic gv;
                logic [DW-1:0] gd;
                r  = cyc - l + 1;
                ev = (r >= 0) && hist_v[r][k];
                if (ev) hold[l-1][k] = hist_d[r][k];
                gv = (l == 1) ? l1_rd_data_valid[k] : l2_rd_data_valid[k];
                gd = (l == 1) ? l1_rd_data[k*DW +: DW] : l2_rd_data[k*DW +: DW];
                check($sformatf("lat%0d_ch%0d_valid", l, k), gv, ev);
                check($sformatf("lat%0d_ch%0d_data", l, k), gd, hold[l-1][k]);
            end
        end
        check("lat1_rd_err", l1_rd_err, m_err);
        check("lat2_rd_err", l2_rd_err, m_err);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] beat_data(input int kind, input int addr);
        case (kind)
            0:       return DW'(addr) ^ 16'hA5A5;
            1:       return '0;
            default: return DW'($urandom);
        endcase
    endfunction

    // Streams a full table; optional gaps, a mid-load restart, or an early abort.
    task automatic load_table(input int kind, input int gap_pct, input bit issue_start,
                              input int restart_at, input int abort_at, input bit noisy);
        int  i = 0;
        int  guard = 0;
        bit  restarted = 1'b0;
        if (issue_start) begin
            idle_inputs();
            load_start = 1'b1;
            load_valid = 1'b1;
            load_data  = 16'hDEAD;
            step();
        end
        while (i < DEPTH && guard < 4 * DEPTH) begin
            guard++;
            idle_inputs();
            if (abort_at >= 0 && i == abort_at) break;
            if (noisy && $urandom_range(99) < 5) begin
                rd_valid = NCH'($urandom);
                rd_addr  = (NCH*AW)'($urandom);
            end
            if (!restarted && i == restart_at) begin
                restarted  = 1'b1;
                load_start = 1'b1;
                load_valid = 1'b1;
                load_data  = beat_data(kind, 0);
                step();
                i = 1;
                continue;
            end
            load_valid = ($urandom_range(99) >= gap_pct);
            load_data  = beat_data(kind, i);
            step();
            if (load_valid) i++;
        end
        idle_inputs();
    endtask

    task automatic rand_reads(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            rd_valid   = NCH'($urandom);
            rd_addr    = (NCH*AW)'($urandom);
            load_valid = ($urandom_range(9) == 0);
            load_data  = DW'($urandom);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        cyc = 0;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        do_reset(2);
        check("reset_rd_data_lat1", l1_rd_data, 0);
        check("reset_rd_data_lat2", l2_rd_data, 0);
        check("reset_table_ready", l1_table_ready, 1'b0);

        // Reads before any load flag an error and return nothing.
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            rd_valid = 2'b01;
            rd_addr  = (NCH*AW)'($urandom);
            step();
        end
        idle_inputs();
        step();
        step();
        check("preload_rd_err_sticky", l1_rd_err, 1'b1);
        check("preload_no_valid", l1_rd_data_valid, 2'b00);
        do_reset(1);
        check("rd_err_cleared_by_reset", l1_rd_err, 1'b0);

        done_seen    = 0;
        ready_cycles = 0;
        load_table(0, 0, 1'b1, -1, -1, 1'b0);
        check("first_load_done_count", done_seen, 1);
        check("first_load_ready_cycles", ready_cycles, 256);
        check("first_load_table_ready", l1_table_ready, 1'b1);

        idle_inputs();
        rd_valid = 2'b11;
        rd_addr  = {8'hFF, 8'h00};
        step();
        check("dual_read_valid", l1_rd_data_valid, 2'b11);
        check("dual_read_data", l1_rd_data, 32'hA55A_A5A5);

        // Back-to-back reads on ch0 through the two-stage pipeline.
        idle_inputs();
        rd_valid = 2'b01;
        rd_addr  = 16'h0001;
        step();
        rd_addr  = 16'h0002;
        step();
        check("lat2_b2b_0_valid", l2_rd_data_valid[0], 1'b1);
        check("lat2_b2b_0_data", l2_rd_data[15:0], 16'hA5A4);
        rd_addr  = 16'h0003;
        step();
        check("lat2_b2b_1_valid", l2_rd_data_valid[0], 1'b1);
        check("lat2_b2b_1_data", l2_rd_data[15:0], 16'hA5A7);
        idle_inputs();
        step();
        check("lat2_b2b_2_valid", l2_rd_data_valid[0], 1'b1);
        check("lat2_b2b_2_data", l2_rd_data[15:0], 16'hA5A6);
        step();
        check("lat2_b2b_end_valid", l2_rd_data_valid[0], 1'b0);
        check("lat2_b2b_hold_data", l2_rd_data[15:0], 16'hA5A6);

        rand_reads(300);

        // Reload from READY with a read in the same cycle: old data comes back.
        idle_inputs();
        load_start = 1'b1;
        rd_valid   = 2'b01;
        rd_addr    = 16'h0005;
        step();
        check("reload_read_old_valid", l1_rd_data_valid[0], 1'b1);
        check("reload_read_old_data", l1_rd_data[15:0], 16'hA5A0);
        check("reload_table_ready_drop", l1_table_ready, 1'b0);
        load_table(1, 30, 1'b0, -1, -1, 1'b0);
        step();
        rd_valid = 2'b01;
        rd_addr  = 16'h0005;
        step();
        idle_inputs();
        check("zero_table_read", l1_rd_data[15:0], 16'h0000);
        check("zero_table_valid", l1_rd_data_valid[0], 1'b1);

        rand_reads(200);

        load_table(2, 20, 1'b1, 77, -1, 1'b1);
        rand_reads(300);

        // Reset partway through a load, then a clean reload.
        load_table(0, 0, 1'b1, -1, 100, 1'b0);
        do_reset(1);
        check("midload_reset_load_ready", l1_load_ready, 1'b0);
        check("midload_reset_table_ready", l1_table_ready, 1'b0);
        check("midload_reset_rd_err", l1_rd_err, 1'b0);
        check("midload_reset_rd_data", l2_rd_data, 0);
        done_seen = 0;
        load_table(0, 10, 1'b1, -1, -1, 1'b0);
        check("reload_done_count", done_seen, 1);
        rand_reads(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
